// File: rtl/alu_sequencer.sv
// Sequenced, back-pressured request/response front end for a 16-bit ALU.
// Shift-left and multiply iterate through the same adder over several cycles.

module alu16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  input  logic        nb,
  input  logic        ic,
  input  logic        zb,
  output logic [15:0] out,
  output logic        co
);
  logic [15:0] bx_s;
  logic [16:0] sum_s;

  assign bx_s  = (zb ? 16'd0 : b) ^ {16{nb}};
  assign sum_s = {1'b0, a} + {1'b0, bx_s} + {16'd0, ci};
  assign out   = ic ? (a ^ bx_s) : sum_s[15:0];
  assign co    = ic ? 1'b0 : sum_s[16];
endmodule

module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_carry
);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_INC = 3'd3;
  localparam logic [2:0] OP_DEC = 3'd4;
  localparam logic [2:0] OP_NEG = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [2:0]  op_r;
  logic [15:0] acc_r;
  logic [15:0] mcand_r;
  logic [15:0] mplier_r;
  logic [4:0]  cnt_r;
  logic        sticky_r;
  logic [15:0] rsp_data_r;
  logic        rsp_carry_r;
  logic        rsp_valid_r;

  logic [15:0] alu_a_s;
  logic [15:0] alu_b_s;
  logic [15:0] alu_out_s;
  logic        alu_ci_s;
  logic        alu_nb_s;
  logic        alu_ic_s;
  logic        alu_zb_s;
  logic        alu_co_s;
  logic        last_s;
  logic        carry_s;

  alu16 u_alu (
    .a   (alu_a_s),
    .b   (alu_b_s),
    .ci  (alu_ci_s),
    .nb  (alu_nb_s),
    .ic  (alu_ic_s),
    .zb  (alu_zb_s),
    .out (alu_out_s),
    .co  (alu_co_s)
  );

  // ALU control decode from the latched opcode; acc_r holds A (or the product), mcand_r holds B
  always_comb begin
    alu_a_s  = acc_r;
    alu_b_s  = mcand_r;
    alu_ci_s = 1'b0;
    alu_nb_s = 1'b0;
    alu_ic_s = 1'b0;
    alu_zb_s = 1'b0;
    case (op_r)
      OP_ADD: begin
        alu_ci_s = 1'b0;
      end
      OP_SUB: begin
        alu_ci_s = 1'b1;
        alu_nb_s = 1'b1;
      end
      OP_XOR: begin
        alu_ic_s = 1'b1;
      end
      OP_INC: begin
        alu_ci_s = 1'b1;
        alu_zb_s = 1'b1;
      end
      OP_DEC: begin
        alu_nb_s = 1'b1;
        alu_zb_s = 1'b1;
      end
      OP_NEG: begin
        alu_a_s  = 16'd0;
        alu_b_s  = acc_r;
        alu_ci_s = 1'b1;
        alu_nb_s = 1'b1;
      end
      OP_SHL: begin
        // a zero count turns the single cycle into a pass-through of A
        alu_b_s  = acc_r;
        alu_zb_s = (cnt_r == 5'd0);
      end
      OP_MUL: begin
        alu_zb_s = ~mplier_r[0];
      end
      default: begin
        alu_a_s = acc_r;
      end
    endcase
  end

  // Termination of EXEC and the carry reported with the result
  always_comb begin
    if ((op_r == OP_SHL) || (op_r == OP_MUL)) begin
      last_s = (cnt_r <= 5'd1);
    end else begin
      last_s = 1'b1;
    end
    carry_s = sticky_r | alu_co_s;
  end

  // Sequencer FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      op_r        <= 3'd0;
      acc_r       <= 16'd0;
      mcand_r     <= 16'd0;
      mplier_r    <= 16'd0;
      cnt_r       <= 5'd0;
      sticky_r    <= 1'b0;
      rsp_data_r  <= 16'd0;
      rsp_carry_r <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid_r <= 1'b0;
          if (req_valid) begin
            op_r     <= req_op;
            sticky_r <= 1'b0;
            mplier_r <= req_b;
            if (req_op == OP_MUL) begin
              acc_r   <= 16'd0;
              mcand_r <= req_a;
              cnt_r   <= 5'd16;
            end else begin
              acc_r   <= req_a;
              mcand_r <= req_b;
              cnt_r   <= {1'b0, req_b[3:0]};
            end
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          acc_r    <= alu_out_s;
          sticky_r <= carry_s;
          mcand_r  <= {mcand_r[14:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[15:1]};
          if (cnt_r != 5'd0) begin
            cnt_r <= cnt_r - 5'd1;
          end else begin
            cnt_r <= 5'd0;
          end
          if (last_s) begin
            rsp_data_r  <= alu_out_s;
            rsp_carry_r <= carry_s;
            rsp_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= EXEC;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_r == IDLE) && !rst;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_carry = rsp_carry_r;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: scoreboard queue of expected results,
// latency, back-pressure and mid-operation reset checks.

module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_carry;

  typedef struct {
    logic [15:0] data;
    logic        carry;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  alu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour, returns {carry, data}
  function automatic logic [16:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] s;
    logic [16:0] t;
    logic [15:0] acc;
    logic [15:0] mc;
    logic [15:0] mp;
    logic        st;
    s = 17'd0;
    case (op)
      3'd0: s = {1'b0, a} + {1'b0, b};
      3'd1: s = {1'b0, a} + {1'b0, ~b} + 17'd1;
      3'd2: s = {1'b0, a ^ b};
      3'd3: s = {1'b0, a} + 17'd1;
      3'd4: s = {1'b0, a} + 17'h0ffff;
      3'd5: s = {1'b0, ~a} + 17'd1;
      3'd6: begin
        acc = a;
        st  = 1'b0;
        for (int i = 0; i < int'(b[3:0]); i++) begin
          t   = {1'b0, acc} + {1'b0, acc};
          st  = st | t[16];
          acc = t[15:0];
        end
        s = {st, acc};
      end
      default: begin
        acc = 16'd0;
        mc  = a;
        mp  = b;
        st  = 1'b0;
        for (int i = 0; i < 16; i++) begin
          if (mp[0]) begin
            t   = {1'b0, acc} + {1'b0, mc};
            st  = st | t[16];
            acc = t[15:0];
          end
          mc = mc << 1;
          mp = mp >> 1;
        end
        s = {st, acc};
      end
    endcase
    return s;
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [15:0] b);
    if (op < 3'd6) return 2;
    if (op == 3'd6) return (b[3:0] == 4'd0) ? 2 : 1 + int'(b[3:0]);
    return 17;
  endfunction

  // Called at a negedge; returns at the negedge after the request handshake
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit keep);
    int          w = 0;
    exp_t        e;
    logic [16:0] r;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    while (req_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("accept_in_time", 32'(w < 40), 32'd1);
    @(posedge clk);
    r      = ref_op(op, a, b);
    e.data = r[15:0];
    e.carry = r[16];
    e.lat  = lat_of(op, b);
    sbq.push_back(e);
    @(negedge clk);
    if (!keep) begin
      req_valid = 1'b0;
      req_op    = ~op;
      req_a     = ~a;
      req_b     = ~b;
    end
  endtask

  // Waits for rsp_valid, checks it against the scoreboard, then holds off rsp_ready
  task automatic wait_rsp(input int hold);
    int          lat = 1;
    bit          rdy_seen = 1'b0;
    exp_t        e;
    logic [15:0] d;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      if (req_ready !== 1'b0) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("rsp_valid_in_time", 32'(rsp_valid), 32'd1);
    chk("scoreboard_nonempty", 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("latency", lat, e.lat);
      chk("rsp_data", 32'(rsp_data), 32'(e.data));
      chk("rsp_carry", 32'(rsp_carry), 32'(e.carry));
    end
    d = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_data_stable", 32'(rsp_data), 32'(d));
      chk("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    chk("busy_req_ready", 32'(rdy_seen), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_dropped", 32'(rsp_valid), 32'd0);
  endtask

  logic [2:0]  t_op[12] = '{3'd0, 3'd0, 3'd1, 3'd4, 3'd2, 3'd5, 3'd3, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7};
  logic [15:0] t_a[12]  = '{16'd9, 16'd65534, 16'd10, 16'd0, 16'd10, 16'd5, 16'd65535,
                            16'd3, 16'h8001, 16'd7, 16'd300, 16'd0};
  logic [15:0] t_b[12]  = '{16'd8, 16'd2, 16'd4, 16'd0, 16'd9, 16'd0, 16'd0,
                            16'd4, 16'd1, 16'd0, 16'd300, 16'd1234};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 16'd0;
    req_b     = 16'd0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_carry", 32'(rsp_carry), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 1'b0);
      wait_rsp(0);
    end

    for (int i = 0; i < 8; i++) begin
      issue(3'($urandom_range(7, 0)), 16'($urandom), 16'($urandom), 1'b0);
      wait_rsp(i % 3);
    end

    // back-pressure with the next request already waiting
    issue(3'd0, 16'd100, 16'd23, 1'b1);
    req_op = 3'd2;
    req_a  = 16'h00f0;
    req_b  = 16'h0ff0;
    wait_rsp(3);
    chk("bp_next_ready", 32'(req_ready), 32'd1);
    issue(3'd2, 16'h00f0, 16'h0ff0, 1'b0);
    wait_rsp(0);

    // reset on the 5th EXEC cycle of a multiply
    issue(3'd7, 16'd300, 16'd300, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", 32'(req_ready), 32'd1);
    sbq.delete();
    @(negedge clk);
    issue(3'd0, 16'd1, 16'd1, 1'b0);
    wait_rsp(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Request/response controller that owns one instance of the 16-bit `ALU` (ports a, b, ci, nb, ic, zb, out, co) and drives its control lines. Single-cycle ops map directly onto ALU control encodings. Shift-left and multiply run as multi-cycle iterations through the same adder. It sits between the instruction/decode side, which issues requests, and any consumer of results, and gives the design a sequenced, back-pressured path to the ALU.

## Interface
- No parameters; datapath width fixed at 16 bits.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_op  input  3  opcode: 0 ADD, 1 SUB, 2 XOR, 3 INC, 4 DEC, 5 NEG, 6 SHL, 7 MUL
- req_a  input  16  operand A
- req_b  input  16  operand B; for SHL only bits [3:0] are used as the shift count
- rsp_valid  output  1  result present
- rsp_ready  input  1  consumer takes the result
- rsp_data  output  16  result, low 16 bits
- rsp_carry  output  1  carry flag, defined per op below

## Operation
- ALU model, for both design and bench reference:
  - b' = (zb ? 0 : b) ^ {16{nb}}
  - out = ic ? (a ^ b') : a + b' + ci, truncated to 16 bits
  - co = carry out of the add; co = 0 when ic = 1
- Control encodings as {ALU a, ALU b, ci, nb, ic, zb}:
  - ADD: {A, B, 0, 0, 0, 0}
  - SUB: {A, B, 1, 1, 0, 0}
  - XOR: {A, B, 0, 0, 1, 0}
  - INC: {A, -, 1, 0, 0, 1}
  - DEC: {A, -, 0, 1, 0, 1}
  - NEG: {0, A, 1, 1, 0, 0}
- States: IDLE, EXEC, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch op, A and B; load cnt (see below); clear sticky carry; go to EXEC.
- EXEC, single-cycle ops (0–5): one cycle; out → rsp_data and co → rsp_carry at the edge; go to DONE.
- EXEC, SHL:
  - acc = A; cnt = B[3:0].
  - Each EXEC cycle drives {acc, acc, 0, 0, 0, 0}; acc ← out; sticky |= co; cnt decrements.
  - Leave EXEC when cnt reaches 0.
  - cnt = 0 at acceptance: one pass-through cycle {acc, -, 0, 0, 0, 1}; rsp_data = A, rsp_carry = 0.
- EXEC, MUL:
  - prod = 0; mcand = A; mplier = B; exactly 16 EXEC cycles.
  - Each cycle drives {prod, mcand, 0, 0, 0, ~mplier[0]}; prod ← out; sticky |= co; mcand ← mcand << 1; mplier ← mplier >> 1.
  - rsp_carry = sticky OR of adder carries. This is not a full-product overflow flag.
- DONE:
  - rsp_valid = 1; rsp_data and rsp_carry held stable.
  - On rsp_ready: go to IDLE. No request is accepted in the same cycle.
- req_ready = 0 in EXEC and DONE, and forced 0 while rst is high.
- Only one operation is in flight at a time.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_data 0, rsp_carry 0, all internal registers 0. req_ready is 1 from the first cycle after rst deasserts.
- Reset mid-operation (EXEC or DONE): the operation is abandoned, no response is produced, and the reset values above apply on the next edge.
- Latency from the request-handshake edge to the edge that raises rsp_valid:
  - 2 edges for ops 0–5
  - 1 + max(1, n) edges for SHL by n
  - 17 edges for MUL
- Minimum issue interval: 3 cycles (accept, EXEC, DONE with rsp_ready already high).
- Back-pressure: rsp_valid may stay high indefinitely; rsp_data and rsp_carry must not change while rsp_valid = 1.
- Request inputs are sampled only on the handshake edge; later changes to them have no effect.
- Unknown opcodes are not possible, since all 3-bit codes are defined.

## Test plan
- ADD 9 + 8 → rsp_data 17, rsp_carry 0, rsp_valid 2 edges after the handshake. ADD 65534 + 2 → 0, carry 1. SUB 10 − 4 → 6, carry 1. DEC 0 → 65535, carry 0.
- XOR 10 ^ 9 → 3, carry 0. NEG 5 → 65531. INC 65535 → 0, carry 1.
- SHL 3 by 4 → 48, carry 0, rsp_valid after 5 edges. SHL 0x8001 by 1 → 2, carry 1. SHL 7 by 0 → 7 after 2 edges.
- MUL 300 × 300 → 24464, carry 0, rsp_valid after 17 edges; req_ready must stay 0 for the whole run. MUL 0 × 1234 → 0.
- Back-pressure: hold rsp_ready low for 3 cycles after rsp_valid with req_valid high throughout. Required: rsp_data unchanged, req_ready 0, and the next request accepted only in the cycle after the rsp handshake.
- Assert rst on the 5th EXEC cycle of a MUL. Required next edge: rsp_valid 0, rsp_data 0. req_ready is 1 from the first cycle after rst deasserts, and a following ADD 1 + 1 returns 2.
